// File: rtl/bullet_ctrl_if.sv
// bullet_ctrl_if: raster/pixel bus between the video timing + map side (master) and bullet_ctrl (slave).
//   display_enable_i, hpos_i, vpos_i, frame_tick_i, all_hard_block_i : raster and map info into the bullet
//   bullet_collide_o, bullet_enable_o, bullet_{blue,green,red}_o      : bullet pixel results out
interface bullet_ctrl_if #(parameter int COLOR_BITS = 24);
  logic                    display_enable_i;
  logic [9:0]              hpos_i;
  logic [9:0]              vpos_i;
  logic                    frame_tick_i;
  logic                    all_hard_block_i;
  logic                    bullet_collide_o;
  logic                    bullet_enable_o;
  logic [COLOR_BITS/3-1:0] bullet_blue_o;
  logic [COLOR_BITS/3-1:0] bullet_green_o;
  logic [COLOR_BITS/3-1:0] bullet_red_o;
  modport master (
    output display_enable_i, hpos_i, vpos_i, frame_tick_i, all_hard_block_i,
    input  bullet_collide_o, bullet_enable_o, bullet_blue_o, bullet_green_o, bullet_red_o
  );
  modport slave (
    input  display_enable_i, hpos_i, vpos_i, frame_tick_i, all_hard_block_i,
    output bullet_collide_o, bullet_enable_o, bullet_blue_o, bullet_green_o, bullet_red_o
  );
endinterface

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: single tank bullet FSM (fire, fly, hit-detect, brick erase pulse, optional explosion via BULLET_EXPLODE_EN).
//   clk_i, reset_i (sync, active-high) ; fire_i, dir_i, tank_x_i, tank_y_i : player/tank inputs
//   bullet_active_o : bullet in FLY or HIT ; bus (bullet_ctrl_if.slave) : raster in, pixel/collide out
module bullet_ctrl #(
  parameter int COLOR_BITS  = 24,
  parameter int BULLET_SIZE = 4,
  parameter int SPEED       = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       fire_i,
  input  logic [1:0] dir_i,
  input  logic [9:0] tank_x_i,
  input  logic [9:0] tank_y_i,
  output logic       bullet_active_o,
  bullet_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FLY, HIT, EXPLODE} state_t;
  state_t     r_state, w_state_n;
  logic [9:0] r_bx, r_by, w_bx_n, w_by_n;
  logic [1:0] r_bdir, w_bdir_n;
  logic       r_hit, w_hit_n;
  logic       w_in_box, w_hit, w_off, w_draw;
  logic [9:0] w_bx_end, w_by_end, w_bx_mv, w_by_mv;
  assign w_bx_end = r_bx + 10'(BULLET_SIZE);
  assign w_by_end = r_by + 10'(BULLET_SIZE);
  assign w_in_box = bus.hpos_i >= r_bx && bus.hpos_i < w_bx_end && bus.vpos_i >= r_by && bus.vpos_i < w_by_end;
  assign w_hit    = r_hit | (r_state == FLY && bus.display_enable_i && w_in_box && bus.all_hard_block_i);
  // exit when the step would leave the 640x480 visible area
  assign w_off = r_bdir == 2'b00 ? r_by < 10'(SPEED) :
                 r_bdir == 2'b01 ? {1'b0, r_bx} + 11'(SPEED + BULLET_SIZE) > 11'd640 :
                 r_bdir == 2'b10 ? {1'b0, r_by} + 11'(SPEED + BULLET_SIZE) > 11'd480 :
                                   r_bx < 10'(SPEED);
  assign w_bx_mv = r_bdir == 2'b01 ? r_bx + 10'(SPEED) : r_bdir == 2'b11 ? r_bx - 10'(SPEED) : r_bx;
  assign w_by_mv = r_bdir == 2'b10 ? r_by + 10'(SPEED) : r_bdir == 2'b00 ? r_by - 10'(SPEED) : r_by;
`ifdef BULLET_EXPLODE_EN
  logic [2:0] r_cnt, w_cnt_n;
  logic       w_ex_box;
  logic [10:0] w_cx, w_cy;
  // 8x8 box centred on the bullet, offset by +4 on both sides so it never underflows near the edges
  assign w_cx     = {1'b0, r_bx} + 11'(BULLET_SIZE / 2);
  assign w_cy     = {1'b0, r_by} + 11'(BULLET_SIZE / 2);
  assign w_ex_box = {1'b0, bus.hpos_i} + 11'd4 >= w_cx && {1'b0, bus.hpos_i} + 11'd4 < w_cx + 11'd8 &&
                    {1'b0, bus.vpos_i} + 11'd4 >= w_cy && {1'b0, bus.vpos_i} + 11'd4 < w_cy + 11'd8;
  assign w_draw   = bus.display_enable_i && (r_state == EXPLODE ? w_ex_box : r_state == FLY && w_in_box);
  assign bus.bullet_blue_o  = (w_draw && r_state == FLY) ? '1 : '0;
  assign bus.bullet_green_o = (w_draw && r_state == FLY) ? '1 : '0;
`else
  assign w_draw   = bus.display_enable_i && r_state == FLY && w_in_box;
  assign bus.bullet_blue_o  = w_draw ? '1 : '0;
  assign bus.bullet_green_o = w_draw ? '1 : '0;
`endif
  assign bus.bullet_red_o     = w_draw ? '1 : '0;
  assign bus.bullet_enable_o  = w_draw;
  assign bus.bullet_collide_o = r_state == HIT && bus.display_enable_i && w_in_box;
  assign bullet_active_o      = r_state == FLY || r_state == HIT;
  always_comb begin
    w_state_n = r_state;
    w_bx_n    = r_bx;
    w_by_n    = r_by;
    w_bdir_n  = r_bdir;
    w_hit_n   = bus.frame_tick_i ? 1'b0 : w_hit;
`ifdef BULLET_EXPLODE_EN
    w_cnt_n   = r_cnt;
`endif
    if (bus.frame_tick_i)
      case (r_state)
        IDLE: if (fire_i) begin
          w_state_n = FLY;
          w_bx_n    = tank_x_i + 10'(16 - BULLET_SIZE / 2);
          w_by_n    = tank_y_i + 10'(16 - BULLET_SIZE / 2);
          w_bdir_n  = dir_i;
        end
        FLY: if (w_hit) w_state_n = HIT;
          else if (w_off) w_state_n = IDLE;
          else begin
            w_bx_n = w_bx_mv;
            w_by_n = w_by_mv;
          end
`ifdef BULLET_EXPLODE_EN
        HIT: begin
          w_state_n = EXPLODE;
          w_cnt_n   = 3'd7;
        end
        EXPLODE: begin
          w_state_n = r_cnt == 3'd0 ? IDLE : EXPLODE;
          w_cnt_n   = r_cnt == 3'd0 ? 3'd0 : r_cnt - 3'd1;
        end
`endif
        default: w_state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_bx    <= '0;
      r_by    <= '0;
      r_bdir  <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bx    <= w_bx_n;
      r_by    <= w_by_n;
      r_bdir  <= w_bdir_n;
      r_hit   <= w_hit_n;
    end
  end
`ifdef BULLET_EXPLODE_EN
  always_ff @(posedge clk_i) r_cnt <= reset_i ? 3'd0 : w_cnt_n;
`endif
endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 Parameter COLOR_BITS, default 24; total pixel colour width, split equally into blue/green/red.
REQ-002 Parameter BULLET_SIZE, default 4; bullet square edge in pixels.
REQ-003 Parameter SPEED, default 4; pixels moved per frame.
REQ-004 clk_i  in  1  single clock for all state.
REQ-005 reset_i  in  1  synchronous, active-high reset; one clock, sampled on rising clk_i edge.
REQ-006 display_enable_i  in  1  raster pixel visible.
REQ-007 hpos_i, vpos_i  in  10 each  raster pixel coordinates.
REQ-008 frame_tick_i  in  1  one-cycle pulse at end of each frame.
REQ-009 fire_i  in  1  fire request level from the player.
REQ-010 dir_i  in  2  tank heading: 00 up, 01 right, 10 down, 11 left.
REQ-011 tank_x_i, tank_y_i  in  10 each  tank upper-left corner; the tank is 32x32.
REQ-012 all_hard_block_i  in  1  map hard-block flag for the current raster pixel.
REQ-013 bullet_collide_o  out  1  drives the map's bullet_collide_i for brick-corner erase.
REQ-014 bullet_active_o  out  1  high in the FLY or HIT state.
REQ-015 bullet_enable_o  out  1  the current pixel belongs to the drawn bullet.
REQ-016 bullet_blue_o, bullet_green_o, bullet_red_o  out  COLOR_BITS/3 each  bullet pixel colour.

Function
REQ-017 FSM states and transitions:
- IDLE, FLY, HIT; plus EXPLODE when enabled per REQ-031.
- All transitions occur only on a clk_i edge where frame_tick_i=1.
REQ-018 Firing from IDLE:
- If fire_i=1 at frame_tick_i, go to FLY.
- bx = tank_x_i+14, by = tank_y_i+14 (constant for BULLET_SIZE=4), latch bdir = dir_i.
REQ-019 fire_i in any state other than IDLE is ignored; only one bullet exists at a time.
REQ-020 Box membership: the raster is "in box" when bx <= hpos_i < bx+BULLET_SIZE and by <= vpos_i < by+BULLET_SIZE, using unsigned 10-bit compare.
REQ-021 Hit sampling in FLY:
- Sticky hit_flag is set on any cycle with display_enable_i & in-box & all_hard_block_i.
- hit_flag is cleared on every frame_tick_i.
REQ-022 FLY at frame_tick_i:
- If hit_flag (including a set on that same cycle), go to HIT; position is held.
- Otherwise add or subtract SPEED on the axis given by bdir.
REQ-023 Off-screen exit: if the move would make by<SPEED (up), bx<SPEED (left), bx+SPEED+BULLET_SIZE>640 (right) or by+SPEED+BULLET_SIZE>480 (down), go to IDLE without entering HIT; no wrap-around.
REQ-024 HIT lasts exactly one frame:
- bullet_collide_o = display_enable_i & in-box, combinational from registered state, zero latency to the raster.
- Next frame_tick_i goes to IDLE, or to EXPLODE per REQ-031.
REQ-025 bullet_collide_o is 0 in every state other than HIT.
REQ-026 Bullet drawing:
- bullet_enable_o = display_enable_i & in-box & state==FLY, zero latency.
- Colour is all-ones on every channel when bullet_enable_o=1, 0 otherwise.
REQ-027 bullet_active_o = (state==FLY or HIT).

Reset
REQ-028 reset_i=1 overrides everything, including a simultaneous frame_tick_i or fire_i.
REQ-029 Reset values:
- state=IDLE, bx=by=0, bdir=00, hit_flag=0, explode counter=0.
- All outputs 0 on the cycle after reset.
- Reset mid-flight or mid-HIT drops the bullet; no collide pulse follows.

Configuration
REQ-030 Macro BULLET_EXPLODE_EN selects the explosion feature.
REQ-031 With BULLET_EXPLODE_EN defined:
- HIT goes to EXPLODE, and a 3-bit frame counter loads 7.
- In EXPLODE, bullet_enable_o = display_enable_i & raster within an 8x8 box centred on the bullet; colour is red channel all-ones, others 0.
- The counter decrements per frame_tick_i; at 0 and frame_tick_i, go to IDLE.
- fire_i is ignored in EXPLODE, and bullet_active_o=0 there.
REQ-032 Without BULLET_EXPLODE_EN: no EXPLODE state and no counter logic; HIT goes directly to IDLE.

Verification
REQ-033 Fire: tank (100,200), dir=01, fire_i=1 at frame_tick -> FLY, bx=114, by=214; next tick -> bx=118.
REQ-034 Hit: all_hard_block_i=1 at raster (120,216) while bx=118, by=214 -> HIT at tick; next frame bullet_collide_o=1 for exactly the 16 visible pixels (118..121, 214..217); then IDLE.
REQ-035 Off-screen: dir=00, by=2 at tick -> IDLE directly, bullet_collide_o never asserted.
REQ-036 Refire blocked: fire_i=1 on every tick while in FLY -> bx/by unchanged by fire, and no reload.
REQ-037 Reset: reset_i=1 during HIT frame -> next cycle state IDLE, all outputs 0; a simultaneous frame_tick_i is ignored.
REQ-038 With BULLET_EXPLODE_EN: after HIT, exactly 8 frames of EXPLODE drawing, then IDLE; fire accepted only on the following tick.
